// File: rtl/cdc_2phase_src_clearable.sv
// Source half of a two-phase (toggle) clock domain crossing with synchronous clear.
//
// Each accepted item toggles async_req_o and latches the item onto async_data_o, which
// then stays stable until the destination toggles async_ack_i back to match. clear_i
// returns async_req_o to 0 so that both halves can be re-aligned without a reset.
//
// Parameters:
//   WIDTH        data width in bits
//   SYNC_STAGES  depth of the acknowledge synchronizer (must be >= 2)
// Ports:
//   clk_i         source-domain clock
//   rst_ni        asynchronous active-low reset
//   clear_i       synchronous clear
//   data_i        item to transfer
//   valid_i       data_i is valid
//   ready_o       an item is accepted this cycle when valid_i is also high
//   async_req_o   toggling request line to the destination half
//   async_ack_i   toggling acknowledge line from the destination half (asynchronous)
//   async_data_o  registered data to the destination half
module cdc_2phase_src_clearable #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             async_req_o,
    input  logic             async_ack_i,
    output logic [WIDTH-1:0] async_data_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StClear = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 req_q, req_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                 ack_synced;

    // Acknowledge synchronizer: stage 0 samples the asynchronous line, the last stage is
    // the only one the control logic looks at.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], async_ack_i};
        end
    end

    assign ack_synced = ack_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        ready_o = (state_q == StIdle) && !clear_i;

        if (clear_i) begin
            // Clear wins over any handshake; data is left alone so the bus never glitches.
            state_d = StClear;
            req_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (valid_i) begin
                        data_d  = data_i;
                        req_d   = ~req_q;
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    // Round trip complete once the returned phase matches our request.
                    if (ack_synced == req_q) begin
                        state_d = StIdle;
                    end
                end
                StClear: begin
                    // Wait for the destination to drop its ack to the idle level as well.
                    if (!ack_synced) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign async_req_o  = req_q;
    assign async_data_o = data_q;

endmodule

// File: tb/tb_cdc_2phase_src_clearable.sv
module tb_cdc_2phase_src_clearable;

    localparam int unsigned W = 8;
    localparam int unsigned S = 2;

    localparam int MIdle  = 0;
    localparam int MBusy  = 1;
    localparam int MClear = 2;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic [W-1:0] data_in;
    logic         valid;
    logic         ready;
    logic         req;
    logic         ack;
    logic [W-1:0] data_out;

    int tests = 0;
    int fails = 0;

    cdc_2phase_src_clearable #(
        .WIDTH       (W),
        .SYNC_STAGES (S)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .data_i       (data_in),
        .valid_i      (valid),
        .ready_o      (ready),
        .async_req_o  (req),
        .async_ack_i  (ack),
        .async_data_o (data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: the block is idle, waiting for an ack, or clearing. The
    // acknowledge is considered seen S edges after it was first sampled.
    int           m_mode = MIdle;
    logic         m_req  = 1'b0;
    logic [W-1:0] m_data = '0;
    logic [S-1:0] m_hist = '0;  // m_hist[0] = most recent ack sample

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= MIdle;
            m_req  <= 1'b0;
            m_data <= '0;
            m_hist <= '0;
        end else begin
            if (clear) begin
                m_mode <= MClear;
                m_req  <= 1'b0;
            end else if (m_mode == MIdle && valid) begin
                m_mode <= MBusy;
                m_req  <= ~m_req;
                m_data <= data_in;
            end else if (m_mode == MBusy && m_hist[S-1] == m_req) begin
                m_mode <= MIdle;
            end else if (m_mode == MClear && !m_hist[S-1]) begin
                m_mode <= MIdle;
            end
            m_hist <= {m_hist[S-2:0], ack};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_ready", 32'(ready), 32'((m_mode == MIdle) && !clear));
        chk("model_req", 32'(req), 32'(m_req));
        chk("model_data", 32'(data_out), 32'(m_data));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int bound);
        int n = 0;
        while (!ready && n < bound) begin
            tick();
            n++;
        end
        tests++;
        if (!ready) begin
            fails++;
            $display("FAIL wait_ready: ready=0 after %0d cycles, required 1", bound);
        end
    endtask

    logic [W-1:0] b2b_data [3];
    logic         b2b_req  [3];

    initial begin
        b2b_data[0] = 8'h01; b2b_data[1] = 8'h00; b2b_data[2] = 8'h01;
        b2b_req[0]  = 1'b0;  b2b_req[1]  = 1'b1;  b2b_req[2]  = 1'b0;

        rst_n   = 1'b0;
        clear   = 1'b0;
        valid   = 1'b0;
        data_in = '0;
        ack     = 1'b0;

        // Reset
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        #21 rst_n = 1'b1;
        tick();
        chk("rel_ready", 32'(ready), 32'd1);
        chk("rel_req", 32'(req), 32'd0);

        // Single transfer, ack looped back 3 cycles later
        data_in = 8'h01;
        valid   = 1'b1;
        tick();
        valid = 1'b0;
        chk("single_req", 32'(req), 32'd1);
        chk("single_data", 32'(data_out), 32'h01);
        chk("single_busy", 32'(ready), 32'd0);
        tick();
        tick();
        ack = 1'b1;
        tick();
        chk("single_ack_e0", 32'(ready), 32'd0);
        tick();
        chk("single_ack_e1", 32'(ready), 32'd0);
        tick();
        chk("single_ack_e2", 32'(ready), 32'd1);

        // Back-to-back with valid held high; req continues from 1
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = b2b_data[i];
            wait_ready(10);
            tick();
            if (i == 2) valid = 1'b0;
            chk("b2b_req", 32'(req), 32'(b2b_req[i]));
            chk("b2b_data", 32'(data_out), 32'(b2b_data[i]));
            chk("b2b_busy", 32'(ready), 32'd0);
            tick();
            ack = b2b_req[i];
        end
        wait_ready(10);

        // Clear mid-transfer, ack held at 0
        data_in = 8'h77;
        valid   = 1'b1;
        tick();
        valid = 1'b0;
        chk("clr_req_before", 32'(req), 32'd1);
        clear = 1'b1;
        #1;
        chk("clr_ready_comb", 32'(ready), 32'd0);
        tick();
        clear = 1'b0;
        chk("clr_req_after", 32'(req), 32'd0);
        chk("clr_data_hold", 32'(data_out), 32'h77);
        chk("clr_ready_low", 32'(ready), 32'd0);
        tick();
        chk("clr_ready_back", 32'(ready), 32'd1);

        // Valid held during BUSY with changing data
        data_in = 8'h3C;
        valid   = 1'b1;
        tick();
        chk("vwb_req", 32'(req), 32'd1);
        for (int i = 0; i < 4; i++) begin
            data_in = W'($urandom);
            tick();
            chk("vwb_req_hold", 32'(req), 32'd1);
            chk("vwb_data_hold", 32'(data_out), 32'h3C);
        end
        valid = 1'b0;
        ack   = 1'b1;
        wait_ready(8);

        // Clear plus valid with ack stuck at 1
        clear   = 1'b1;
        valid   = 1'b1;
        data_in = 8'hEE;
        tick();
        clear = 1'b0;
        valid = 1'b0;
        chk("cv_req", 32'(req), 32'd0);
        chk("cv_data", 32'(data_out), 32'h3C);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stuck_ready", 32'(ready), 32'd0);
        end
        ack = 1'b0;
        tick();
        chk("unstick_e0", 32'(ready), 32'd0);
        tick();
        chk("unstick_e1", 32'(ready), 32'd0);
        tick();
        chk("unstick_e2", 32'(ready), 32'd1);

        // Clear plus valid from a clean idle: no toggle at all
        clear   = 1'b1;
        valid   = 1'b1;
        data_in = 8'h99;
        tick();
        clear = 1'b0;
        valid = 1'b0;
        chk("cv2_req", 32'(req), 32'd0);
        chk("cv2_data", 32'(data_out), 32'h3C);
        tick();
        chk("cv2_ready", 32'(ready), 32'd1);

        // Reset mid-transfer with ack high
        data_in = 8'h42;
        valid   = 1'b1;
        tick();
        valid = 1'b0;
        chk("mrst_req_before", 32'(req), 32'd1);
        chk("mrst_data_before", 32'(data_out), 32'h42);
        #2;
        ack   = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mrst_ready", 32'(ready), 32'd1);
        chk("mrst_req", 32'(req), 32'd0);
        chk("mrst_data", 32'(data_out), 32'd0);
        #10 rst_n = 1'b1;
        #1;
        chk("mrel_req", 32'(req), 32'd0);
        tick();
        chk("mrel_ready", 32'(ready), 32'd1);
        chk("mrel_data", 32'(data_out), 32'd0);
        ack = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
